sum_block_averager: RTL and testbench



---
 rtl/sum_block_averager.sv | 101 ++++++++++
 tb/tb_sum_block_averager.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_block_averager.sv
// Block accumulator for the adder-stage sum stream.
// Emits block sum and truncated mean on a valid/ready port.
module sum_block_averager #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W+LOG2_N-1:0] out_sum,
    output logic [DATA_W-1:0]        out_mean,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LOG2_N-1:0]        sample_cnt
);

    localparam int SUM_W = DATA_W + LOG2_N;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              r_state;
    logic [SUM_W-1:0]    r_acc;
    logic [LOG2_N-1:0]   r_cnt;
    logic [SUM_W-1:0]    r_sum;
    logic [DATA_W-1:0]   r_mean;
    logic                r_valid;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_last;
    logic [SUM_W-1:0]    w_acc_next;
    logic [DATA_W-1:0]   w_mean_next;

    // Handshake and next-sum decode; the Nth sample closes the block.
    always_comb begin
        w_in_ready  = (r_state == ST_ACCUM) && !clear;
        w_accept    = in_valid && w_in_ready;
        w_last      = (r_cnt == {LOG2_N{1'b1}});
        w_acc_next  = r_acc + {{LOG2_N{1'b0}}, in_data};
        w_mean_next = w_acc_next[SUM_W-1:LOG2_N];
    end

    // Block FSM: clear overrides everything, HOLD waits for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_mean  <= '0;
            r_valid <= 1'b0;
        end else if (clear) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_mean  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_sum   <= w_acc_next;
                            r_mean  <= w_mean_next;
                            r_valid <= 1'b1;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_HOLD;
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + LOG2_N'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_sum    = r_sum;
    assign out_mean   = r_mean;
    assign out_valid  = r_valid;
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_sum_block_averager.sv
// Scoreboard bench for sum_block_averager (DATA_W=8, LOG2_N=2).
// Inputs change and outputs are sampled on the falling edge.
module tb_sum_block_averager;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] out_sum;
    logic [7:0] out_mean;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] sample_cnt;

    typedef struct {
        logic [9:0] sum;
        logic [7:0] mean;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec;
    int   n_err;

    sum_block_averager #(.DATA_W(8), .LOG2_N(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sum    (out_sum),
        .out_mean   (out_mean),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sample_cnt (sample_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
    endtask

    task automatic push_exp(input int sum);
        exp_t x;
        x.sum  = 10'(sum);
        x.mean = 8'(sum / 4);
        sb.push_back(x);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_mean !== 8'd0) begin
            n_err++;
            $display("FAIL reset_out: valid=%b sum=%0d mean=%0d want 0 0 0",
                     out_valid, out_sum, out_mean);
        end
        n_vec++;
        if (sample_cnt !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ctl: cnt=%0d ready=%b want 0 1", sample_cnt, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send(10); send(20); send(30);
        push_exp(101);
        send(41);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_valid: out_valid=%b want 1", out_valid);
        end
        e = sb.pop_front();
        n_vec++;
        if (out_sum !== e.sum || out_mean !== e.mean) begin
            n_err++;
            $display("FAIL basic_data: sum=%0d mean=%0d want %0d %0d",
                     out_sum, out_mean, e.sum, e.mean);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_max;
        out_ready = 1'b1;
        push_exp(1020);
        for (int i = 0; i < 4; i++) send(8'd255);
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== e.sum || out_mean !== e.mean) begin
            n_err++;
            $display("FAIL max_data: valid=%b sum=%0d mean=%0d want 1 %0d %0d",
                     out_valid, out_sum, out_mean, e.sum, e.mean);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        push_exp(10);
        send(1); send(2); send(3); send(4);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'd99;
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_sum !== e.sum || out_mean !== e.mean
                || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b sum=%0d mean=%0d ready=%b want 1 %0d %0d 0",
                         i, out_valid, out_sum, out_mean, in_ready, e.sum, e.mean);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || sample_cnt !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: valid=%b cnt=%0d ready=%b want 0 0 1",
                     out_valid, sample_cnt, in_ready);
        end
        push_exp(20);
        for (int i = 0; i < 4; i++) send(8'd5);
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== e.sum || out_mean !== e.mean) begin
            n_err++;
            $display("FAIL bp_next: valid=%b sum=%0d mean=%0d want 1 %0d %0d",
                     out_valid, out_sum, out_mean, e.sum, e.mean);
        end
        @(negedge clk);
    endtask

    task automatic test_clear;
        out_ready = 1'b1;
        send(50); send(60);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd70;
        clear    = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ready: in_ready=%b want 0", in_ready);
        end
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (sample_cnt !== 2'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_cnt: cnt=%0d valid=%b want 0 0", sample_cnt, out_valid);
        end
        push_exp(4);
        for (int i = 0; i < 4; i++) send(8'd1);
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== e.sum || out_mean !== e.mean) begin
            n_err++;
            $display("FAIL clr_block: valid=%b sum=%0d mean=%0d want 1 %0d %0d",
                     out_valid, out_sum, out_mean, e.sum, e.mean);
        end
        @(negedge clk);
    endtask

    task automatic test_gapped;
        out_ready = 1'b1;
        push_exp(32);
        for (int k = 1; k <= 4; k++) begin
            send(8'd8);
            @(negedge clk);
            in_valid = 1'b0;
            if (k < 4) begin
                n_vec++;
                if (sample_cnt !== 2'(k) || out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap_cnt%0d: cnt=%0d valid=%b want %0d 0",
                             k, sample_cnt, out_valid, k);
                end
                repeat (2) @(negedge clk);
            end
        end
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== e.sum || out_mean !== e.mean) begin
            n_err++;
            $display("FAIL gap_block: valid=%b sum=%0d mean=%0d want 1 %0d %0d",
                     out_valid, out_sum, out_mean, e.sum, e.mean);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd9);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== 10'd36) begin
            n_err++;
            $display("FAIL ar_hold: valid=%b sum=%0d want 1 36", out_valid, out_sum);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_mean !== 8'd0
            || sample_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL ar_clear: valid=%b sum=%0d mean=%0d cnt=%0d want 0 0 0 0",
                     out_valid, out_sum, out_mean, sample_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ar_ready: in_ready=%b want 1", in_ready);
        end
        out_ready = 1'b1;
        push_exp(16);
        for (int i = 0; i < 4; i++) send(8'd4);
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== e.sum || out_mean !== e.mean) begin
            n_err++;
            $display("FAIL ar_block: valid=%b sum=%0d mean=%0d want 1 %0d %0d",
                     out_valid, out_sum, out_mean, e.sum, e.mean);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_clear();
        test_gapped();
        test_async_reset();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_empty: %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
